// File: rtl/mem_io_resp_if.sv
// CPU memory-controller request/response bus plus host RX/TX byte streams
// for the mem_io_resp block.
interface mem_io_resp_if;
  logic [31:0] rom_a;
  logic        rom_wr;
  logic [7:0]  rom_wn;
  logic [7:0]  rom_rn;
  logic [7:0]  rx_d;
  logic        rx_v;
  logic        rx_rdy;
  logic [7:0]  tx_d;
  logic        tx_v;
  logic        tx_rdy;

  modport master (
    output rom_a, rom_wr, rom_wn, rx_d, rx_v, tx_rdy,
    input  rom_rn, rx_rdy, tx_d, tx_v
  );

  modport slave (
    input  rom_a, rom_wr, rom_wn, rx_d, rx_v, tx_rdy,
    output rom_rn, rx_rdy, tx_d, tx_v
  );
endinterface

// File: rtl/mem_io_resp.sv
// Memory responder: byte RAM plus a memory-mapped DATA/STAT port backed by
// RX (host->CPU) and TX (CPU->host) byte FIFOs. One request per cycle, 1-cycle reads.
module mem_io_resp_fifo #(
  parameter int FD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(FD);
  localparam int CW = PW + 1;

  logic [7:0]    mem [FD];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  // full/empty come from the count at the start of the cycle, so a full
  // FIFO refuses a push even when it is popped in the same cycle
  assign full    = (cnt == CW'(FD));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= din;
  end
endmodule

module mem_io_resp #(
  parameter int AW = 17,
  parameter int FD = 8
) (
  input  logic         clk,
  input  logic         rst,
  mem_io_resp_if.slave bus
);
  logic [7:0]    ram [2**AW];
  logic [AW-1:0] ram_idx;
  logic          io_sel, ram_sel, data_sel, stat_sel;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [7:0]    rx_head, tx_head;
  logic          ovf;
  logic [7:0]    io_rd, io_q, ram_q;
  logic          ram_rd_q;
  logic          unused_addr;

  assign unused_addr = ^bus.rom_a;
  assign ram_idx     = bus.rom_a[AW-1:0];
  assign io_sel      = bus.rom_a[17];
  assign ram_sel     = !io_sel;
  assign data_sel    = io_sel && (bus.rom_a[2:0] == 3'd0);
  assign stat_sel    = io_sel && (bus.rom_a[2:0] == 3'd4);

  mem_io_resp_fifo #(.FD(FD)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.rx_v),
    .din   (bus.rx_d),
    .pop   (data_sel && !bus.rom_wr),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  mem_io_resp_fifo #(.FD(FD)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .push  (data_sel && bus.rom_wr),
    .din   (bus.rom_wn),
    .pop   (bus.tx_rdy),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign bus.rx_rdy = !rx_full;
  assign bus.tx_v   = !tx_empty;
  assign bus.tx_d   = tx_head;

  always_ff @(posedge clk) begin
    if (rst)                                 ovf <= 1'b0;
    else if (data_sel && bus.rom_wr && tx_full) ovf <= 1'b1;
    else if (stat_sel && bus.rom_wr)         ovf <= 1'b0;
  end

  // RAM is never cleared; reset only blocks writes
  always_ff @(posedge clk) begin
    if (!rst && ram_sel && bus.rom_wr) ram[ram_idx] <= bus.rom_wn;
    ram_q <= ram[ram_idx];
  end

  always_comb begin
    io_rd = 8'h00;
    if (!bus.rom_wr) begin
      if (data_sel && !rx_empty) io_rd = rx_head;
      else if (stat_sel)         io_rd = {5'b0, ovf, !rx_empty, tx_full};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rd_q <= 1'b0;
      io_q     <= 8'h00;
    end else begin
      ram_rd_q <= ram_sel && !bus.rom_wr;
      io_q     <= io_rd;
    end
  end

  // both sources are flops, so rom_rn is a registered value
  assign bus.rom_rn = ram_rd_q ? ram_q : io_q;
endmodule

// File: tb/tb_mem_io_resp.sv
// Directed bench for mem_io_resp: queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_io_resp;
  localparam int FD = 8;
  localparam logic [31:0] DATA_A = 32'h0003_0000;
  localparam logic [31:0] STAT_A = 32'h0003_0004;
  localparam logic [31:0] IDLE_A = 32'h0002_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_io_resp_if bus();

  mem_io_resp #(.AW(17), .FD(FD)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] mram [131072];
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       ovf_m = 1'b0;
  logic [7:0] exp_rn = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: state as queues, updated at each rising edge
  always @(posedge clk) begin : model
    int unsigned rxn, txn;
    logic        io, push_tx, pop_rx, set_o, clr_o;
    logic [2:0]  off;
    logic [7:0]  rn;
    if (rst) begin
      rxq.delete();
      txq.delete();
      ovf_m  = 1'b0;
      exp_rn = 8'h00;
    end else begin
      rxn = rxq.size(); txn = txq.size();
      io = bus.rom_a[17]; off = bus.rom_a[2:0];
      rn = 8'h00; push_tx = 0; pop_rx = 0; set_o = 0; clr_o = 0;
      if (bus.rom_wr) begin
        if (!io) mram[bus.rom_a[16:0]] = bus.rom_wn;
        else if (off == 3'd0) begin
          if (txn < FD) push_tx = 1; else set_o = 1;
        end else if (off == 3'd4) clr_o = 1;
      end else begin
        if (!io) rn = mram[bus.rom_a[16:0]];
        else if (off == 3'd0) begin
          if (rxn > 0) begin rn = rxq[0]; pop_rx = 1; end
        end else if (off == 3'd4) rn = {5'b0, ovf_m, (rxn > 0), (txn == FD)};
      end
      if (bus.tx_rdy && txn > 0) void'(txq.pop_front());
      if (push_tx) txq.push_back(bus.rom_wn);
      if (pop_rx) void'(rxq.pop_front());
      if (bus.rx_v && rxn < FD) rxq.push_back(bus.rx_d);
      if (set_o) ovf_m = 1'b1; else if (clr_o) ovf_m = 1'b0;
      exp_rn = rn;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_rom_rn", bus.rom_rn, exp_rn);
      chk("m_tx_v", {7'b0, bus.tx_v}, {7'b0, (txq.size() > 0)});
      if (txq.size() > 0) chk("m_tx_d", bus.tx_d, txq[0]);
      chk("m_rx_rdy", {7'b0, bus.rx_rdy}, {7'b0, (rxq.size() < FD)});
    end
  end

  task automatic req(input logic wr, input logic [31:0] a, input logic [7:0] d);
    bus.rom_wr = wr;
    bus.rom_a  = a;
    bus.rom_wn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req(1'b0, IDLE_A, 8'h00);
  endtask

  initial begin
    bus.rom_wr = 1'b0; bus.rom_a = IDLE_A; bus.rom_wn = 8'h00;
    bus.rx_d = 8'h00; bus.rx_v = 1'b0; bus.tx_rdy = 1'b0;
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    chk("rst_rn", bus.rom_rn, 8'h00);
    chk("rst_tx_v", {7'b0, bus.tx_v}, 8'h00);
    chk("rst_rx_rdy", {7'b0, bus.rx_rdy}, 8'h01);
    chk_en = 1'b1;

    // RAM write then read-back
    req(1'b1, 32'h10, 8'hA5);
    chk("ram_wr_rn0", bus.rom_rn, 8'h00);
    req(1'b0, 32'h10, 8'h00);
    chk("ram_rd", bus.rom_rn, 8'hA5);

    // TX ordering with host backpressure
    req(1'b1, DATA_A, 8'h41);
    req(1'b1, DATA_A, 8'h42);
    req(1'b1, DATA_A, 8'h43);
    chk("tx_v_held", {7'b0, bus.tx_v}, 8'h01);
    chk("tx_head_held", bus.tx_d, 8'h41);
    bus.tx_rdy = 1'b1;
    chk("tx_emit0", bus.tx_d, 8'h41); idle();
    chk("tx_emit1", bus.tx_d, 8'h42); idle();
    chk("tx_emit2", bus.tx_d, 8'h43); idle();
    chk("tx_drained", {7'b0, bus.tx_v}, 8'h00);
    bus.tx_rdy = 1'b0;

    // TX overflow, sticky flag, clear via STAT write
    for (int i = 0; i <= FD; i++) req(1'b1, DATA_A, 8'(8'h60 + i));
    req(1'b0, STAT_A, 8'h00);
    chk("stat_ovf", bus.rom_rn, 8'h05);
    req(1'b1, STAT_A, 8'hFF);
    chk("stat_wr_rn0", bus.rom_rn, 8'h00);
    req(1'b0, STAT_A, 8'h00);
    chk("stat_cleared", bus.rom_rn, 8'h01);
    bus.tx_rdy = 1'b1;
    chk("ovf_head", bus.tx_d, 8'h60);
    for (int i = 0; i < FD; i++) idle();
    chk("ovf_drained", {7'b0, bus.tx_v}, 8'h00);
    bus.tx_rdy = 1'b0;

    // single RX byte read through DATA
    bus.rx_d = 8'h7E; bus.rx_v = 1'b1;
    idle();
    bus.rx_v = 1'b0;
    req(1'b0, STAT_A, 8'h00);
    chk("stat_rx_ne", bus.rom_rn, 8'h02);
    req(1'b0, DATA_A, 8'h00);
    chk("rx_rd", bus.rom_rn, 8'h7E);
    req(1'b0, DATA_A, 8'h00);
    chk("rx_rd_empty", bus.rom_rn, 8'h00);
    req(1'b0, STAT_A, 8'h00);
    chk("stat_rx_e", bus.rom_rn, 8'h00);

    // RX full: push refused while a pop happens in the same cycle
    bus.rx_v = 1'b1;
    for (int i = 0; i < FD; i++) begin
      bus.rx_d = 8'(8'h10 + i);
      idle();
    end
    chk("rx_full_rdy", {7'b0, bus.rx_rdy}, 8'h00);
    bus.rx_d = 8'h99;
    req(1'b0, DATA_A, 8'h00);
    bus.rx_v = 1'b0;
    chk("rx_full_pop", bus.rom_rn, 8'h10);
    chk("rx_fdm1_rdy", {7'b0, bus.rx_rdy}, 8'h01);
    for (int i = 1; i < FD; i++) req(1'b0, DATA_A, 8'h00);
    chk("rx_last", bus.rom_rn, 8'(8'h10 + FD - 1));
    req(1'b0, DATA_A, 8'h00);
    chk("rx_refused", bus.rom_rn, 8'h00);

    // mid-stream reset: FIFOs flushed, RAM preserved, writes ignored
    req(1'b1, 32'h1234, 8'h5C);
    req(1'b1, DATA_A, 8'h01);
    req(1'b1, DATA_A, 8'h02);
    bus.rx_d = 8'h33; bus.rx_v = 1'b1;
    req(1'b1, DATA_A, 8'h03);
    bus.rx_v = 1'b0;
    req(1'b0, 32'h1234, 8'h00);
    chk("pre_rst_rn", bus.rom_rn, 8'h5C);
    rst = 1'b1;
    req(1'b1, 32'h1234, 8'hFF);
    rst = 1'b0;
    chk("rst2_tx_v", {7'b0, bus.tx_v}, 8'h00);
    chk("rst2_rn", bus.rom_rn, 8'h00);
    chk("rst2_rx_rdy", {7'b0, bus.rx_rdy}, 8'h01);
    req(1'b0, STAT_A, 8'h00);
    chk("rst2_stat", bus.rom_rn, 8'h00);
    req(1'b0, 32'h1234, 8'h00);
    chk("rst2_ram", bus.rom_rn, 8'h5C);

    // unmapped I/O read/write have no effect
    req(1'b1, 32'h0002_0002, 8'hEE);
    req(1'b0, 32'h0002_0006, 8'h00);
    chk("unmapped_rd", bus.rom_rn, 8'h00);
    chk("unmapped_tx_v", {7'b0, bus.tx_v}, 8'h00);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_resp.md
MEM_IO_RESP -- requirements
Module: mem_io_resp

Interface
REQ-001 The block SHALL have parameter AW, default 17, giving the RAM byte-address width (2^AW bytes).
REQ-002 The block SHALL have parameter FD, default 8, giving the depth of each I/O FIFO (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port rom_a, input, 32 bits: the byte address presented by the CPU memory controller each cycle.
REQ-006 The block SHALL have port rom_wr, input, 1 bit: 1 means write this cycle, 0 means read.
REQ-007 The block SHALL have port rom_wn, input, 8 bits: the write data byte.
REQ-008 The block SHALL have port rom_rn, output, 8 bits: the registered read data byte.
REQ-009 The block SHALL have port rx_d, input, 8 bits: the host byte to be sent toward the CPU.
REQ-010 The block SHALL have port rx_v, input, 1 bit: rx_d is valid.
REQ-011 The block SHALL have port rx_rdy, output, 1 bit: the RX FIFO is not full.
REQ-012 The block SHALL have port tx_d, output, 8 bits: the byte written by the CPU, taken from the TX FIFO head.
REQ-013 The block SHALL have port tx_v, output, 1 bit: the TX FIFO is not empty.
REQ-014 The block SHALL have port tx_rdy, input, 1 bit: the host accepts tx_d.

Function
REQ-015 Every cycle the block SHALL service exactly one request (rom_a, rom_wr, rom_wn); there is no stall signal.
REQ-016 Decode SHALL be as follows. rom_a[17]=0 selects RAM at index rom_a[AW-1:0]. rom_a[17]=1 selects I/O, which decodes rom_a[2:0] only: 0 = DATA, 4 = STAT, any other value = unmapped.
REQ-017 Read latency SHALL be exactly 1 cycle: rom_rn, registered, equals the data for the request of the previous cycle.
REQ-018 A RAM write SHALL store rom_wn at the end of the cycle; a RAM read of the same address in the following cycle SHALL return the new byte.
REQ-019 After a write cycle of any kind, rom_rn SHALL be 0x00 in the next cycle.
REQ-020 A DATA read SHALL return the RX FIFO head and pop it if the FIFO is non-empty; if the FIFO is empty it SHALL return 0x00 and pop nothing.
REQ-021 A DATA write SHALL push rom_wn into the TX FIFO if the FIFO is not full; if it is full, the byte SHALL be dropped and the sticky ovf flag set.
REQ-022 A STAT read SHALL return {5'b0, ovf, rx_nonempty, tx_full}, sampled before any update in that cycle.
REQ-023 A STAT write, any data, SHALL clear ovf; if ovf would also be set in the same cycle, setting SHALL win (impossible by REQ-015, stated for completeness).
REQ-024 An unmapped I/O read SHALL return 0x00; an unmapped I/O write SHALL be ignored.
REQ-025 An RX push SHALL occur when rx_v and rx_rdy are both high. rx_rdy SHALL be derived from the occupancy count at the start of the cycle, so a full FIFO refuses a push even when a pop happens in the same cycle.
REQ-026 A TX pop SHALL occur when tx_v and tx_rdy are both high; tx_d SHALL be the combinational head and stable while tx_v=1 and tx_rdy=0.
REQ-027 A simultaneous push and pop on a non-full, non-empty FIFO SHALL both succeed, leaving the count unchanged.
REQ-028 A push into an empty FIFO SHALL make the byte visible at the head in the next cycle, not the same cycle.
REQ-029 FIFO pointers SHALL wrap modulo FD; the count SHALL range from 0 to FD inclusive.

Reset
REQ-030 While rst=1 the block SHALL clear both FIFOs (pointers and count), clear ovf, and set rom_rn=0x00, tx_v=0 and rx_rdy=1 from the next edge onward.
REQ-031 While rst=1, requests, pushes and pops SHALL be ignored, and RAM contents SHALL be preserved (not cleared).
REQ-032 Reset asserted mid-stream SHALL discard queued FIFO bytes; the first request after rst falls SHALL be serviced normally.

Verification
REQ-033 The bench SHALL write 0xA5 to RAM address 0x00010, then read it in the next cycle -> rom_rn=0xA5 one cycle after the read request.
REQ-034 The bench SHALL write 0x41, 0x42, 0x43 to 0x30000 with tx_rdy=0 -> tx_v=1 and tx_d=0x41; after raising tx_rdy for 3 cycles -> 0x41, 0x42, 0x43 are emitted in order, then tx_v=0.
REQ-035 The bench SHALL make FD+1 writes to 0x30000 with tx_rdy=0 -> the last byte is dropped, a STAT read returns 0x05, a STAT write follows, and a second STAT read returns 0x01.
REQ-036 The bench SHALL push 0x7E on rx_d, then read 0x30000 twice -> rom_rn=0x7E and then 0x00; STAT bit1 reads 1 before the first read and 0 after it.
REQ-037 The bench SHALL fill RX to FD, then in one cycle assert rx_v together with a DATA read -> the pop occurs, the push is refused (rx_rdy=0 that cycle), and the count becomes FD-1.
REQ-038 The bench SHALL queue 3 TX bytes, then pulse rst for 1 cycle -> tx_v=0 and rom_rn=0x00, while a RAM byte written before the reset still reads back unchanged.
